// File: rtl/fetch_trace_buffer.sv
// fetch_trace_buffer: queues fetched (PC, instruction) pairs and releases one to the display per StepClk rise; TRACE_FREEZE_EN adds a Freeze capture-inhibit port
module fetch_trace_buffer #(
  parameter int DEPTH = 16,
  parameter bit SHOW_UPPER = 1'b0
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      FetchValid,
  input  logic [31:0]               PCResult,
  input  logic [31:0]               Instruction,
  input  logic                      StepClk,
`ifdef TRACE_FREEZE_EN
  input  logic                      Freeze,
`endif
  output logic [15:0]               NumberA,
  output logic [15:0]               NumberB,
  output logic [$clog2(DEPTH):0]    Count,
  output logic                      Overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          s1, s2, s3;
  logic          step, frz, full, empty, want, push, pop;
`ifdef TRACE_FREEZE_EN
  assign frz = Freeze;
`else
  assign frz = 1'b0;
`endif
  assign step  = s2 & ~s3;
  assign full  = Count == FULL_COUNT;
  assign empty = Count == '0;
  assign want  = FetchValid & ~frz;
  assign pop   = step & ~empty;
  assign push  = want & (~full | pop);
  // two-flop synchroniser plus edge flop turns StepClk rises into one-cycle step pulses
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {StepClk, s1, s2};
  // entries hold the two display fields, already selected for the chosen view
  always_ff @(posedge Clk)
    if (push) mem[wr_ptr] <= {SHOW_UPPER ? Instruction[31:16] : PCResult[15:0], Instruction[15:0]};
  // pointers, occupancy, display registers and sticky overflow
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      NumberA  <= '0;
      NumberB  <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        NumberA <= mem[rd_ptr][31:16];
        NumberB <= mem[rd_ptr][15:0];
      end
      Count <= Count + (AW+1)'(push) - (AW+1)'(pop);
      if (want & full & ~pop) Overflow <= 1'b1;
    end
endmodule

// File: tb/tb_fetch_trace_buffer.sv
// tb_fetch_trace_buffer: directed and random stimulus against a queue-based reference model
module tb_fetch_trace_buffer;
  localparam int DEPTH = 16;
  logic        Clk = 1'b0;
  logic        Reset, FetchValid, StepClk, Freeze;
  logic [31:0] PCResult, Instruction;
  logic [15:0] NumberA, NumberB;
  logic [4:0]  Count;
  logic        Overflow;
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [15:0] ma, mb;
  logic        movf, prev;
  int          edge_n;
  int          pend[$];

  fetch_trace_buffer #(.DEPTH(DEPTH), .SHOW_UPPER(1'b0)) dut (
    .Clk(Clk), .Reset(Reset), .FetchValid(FetchValid), .PCResult(PCResult),
    .Instruction(Instruction), .StepClk(StepClk),
`ifdef TRACE_FREEZE_EN
    .Freeze(Freeze),
`endif
    .NumberA(NumberA), .NumberB(NumberB), .Count(Count), .Overflow(Overflow));

  always #5 Clk = ~Clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    pend.delete();
    ma = '0;
    mb = '0;
    movf = 1'b0;
    prev = 1'b0;
  endtask

  task automatic check_all(string tag);
    check({tag, "_count"}, 32'(Count), 32'(q.size()));
    check({tag, "_a"}, 32'(NumberA), 32'(ma));
    check({tag, "_b"}, 32'(NumberB), 32'(mb));
    check({tag, "_ovf"}, 32'(Overflow), 32'(movf));
  endtask

  // one clock: drive at the negedge, apply the rules at the posedge, compare at the next negedge
  task automatic cyc(bit fv, bit sc, bit fz, logic [31:0] pc, logic [31:0] ins);
    bit due, pop, push;
    logic [31:0] e;
    FetchValid = fv; StepClk = sc; Freeze = fz; PCResult = pc; Instruction = ins;
    @(posedge Clk);
    edge_n++;
    due = 1'b0;
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i] == edge_n) begin due = 1'b1; pend.delete(i); end
    if (sc && !prev) pend.push_back(edge_n + 2);
    prev = sc;
    pop  = due && q.size() > 0;
    push = fv && !fz && (q.size() < DEPTH || pop);
    if (fv && !fz && q.size() == DEPTH && !pop) movf = 1'b1;
    if (pop) begin e = q.pop_front(); ma = e[31:16]; mb = e[15:0]; end
    if (push) q.push_back({pc[15:0], ins[15:0]});
    @(negedge Clk);
    check_all("cyc");
  endtask

  task automatic do_reset();
    #1 Reset = 1'b1;
    FetchValid = 1'b0;
    StepClk = 1'b0;
    #1;
    model_clear();
    check_all("async_rst");
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic pulse_step(bit fv, logic [31:0] pc);
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    cyc(fv, 1'b0, 1'b0, pc, 32'h0000_1000 + pc);
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    Reset = 1'b1; FetchValid = 1'b0; StepClk = 1'b0; Freeze = 1'b0;
    PCResult = '0; Instruction = '0; edge_n = 0;
    model_clear();
    repeat (3) @(negedge Clk);
    check_all("reset");
    Reset = 1'b0;
    // single fetch then one StepClk rise
    cyc(1'b1, 1'b0, 1'b0, 32'h4, 32'h2008_000A);
    check("t2_count1", 32'(Count), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);
    check("t2_a", 32'(NumberA), 32'h4);
    check("t2_b", 32'(NumberB), 32'hA);
    check("t2_count0", 32'(Count), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
    // fill past capacity
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 1'b0, 32'(i * 4), 32'h2000_0000 + 32'(i));
    check("t3_full", 32'(Count), 32'd16);
    check("t3_ovf", 32'(Overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      pulse_step(1'b0, 0);
      check("t3_order", 32'(NumberA), 32'(i * 4));
    end
    // full FIFO with push and pop on the same edge
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 32'(i), 32'h10 + 32'(i));
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 32'hBEEF, 32'hCAFE);
    check("t4_count", 32'(Count), 32'd16);
    check("t4_ovf", 32'(Overflow), 32'd0);
    for (int i = 0; i < 16; i++) pulse_step(1'b0, 0);
    check("t4_last_a", 32'(NumberA), 32'hBEEF);
    check("t4_last_b", 32'(NumberB), 32'hCAFE);
    // empty FIFO steps leave the display alone; a long high level pops once
    for (int i = 0; i < 3; i++) pulse_step(1'b0, 0);
    check("t5_hold_a", 32'(NumberA), 32'hBEEF);
    cyc(1'b1, 1'b0, 1'b0, 32'h100, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h104, 32'h2);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0);
    check("t5_one_pop", 32'(Count), 32'd1);
    check("t5_a", 32'(NumberA), 32'h100);
`ifdef TRACE_FREEZE_EN
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 32'(i), 32'(i));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 32'h900, 32'h900);
      cyc(1'b1, 1'b1, 1'b1, 32'h900, 32'h900);
      cyc(1'b1, 1'b0, 1'b1, 32'h900, 32'h900);
      cyc(1'b1, 1'b0, 1'b1, 32'h900, 32'h900);
    end
    check("t6_count", 32'(Count), 32'd0);
    check("t6_ovf", 32'(Overflow), 32'd0);
`endif
    // random traffic with varying push density
    for (int r = 0; r < 4; r++) begin
      int pct;
      bit sc;
      pct = 20 + r * 25;
      sc = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 2) == 0) sc = ~sc;
        cyc($urandom_range(0, 99) < pct, sc,
`ifdef TRACE_FREEZE_EN
            $urandom_range(0, 7) == 0,
`else
            1'b0,
`endif
            $urandom, $urandom);
      end
    end
    // async reset with five entries queued
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 32'h40 + 32'(i), 32'h77);
    pulse_step(1'b0, 0);
    check("t1_pre_count", 32'(Count), 32'd4);
    cyc(1'b1, 1'b0, 1'b0, 32'h60, 32'h88);
    check("t1_count5", 32'(Count), 32'd5);
    do_reset();
    check("t1_count0", 32'(Count), 32'd0);
    check("t1_a0", 32'(NumberA), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
